// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - burst read initiator for the dual-port RAM with credit-gated output FIFO
module ram_burst_reader #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              rd_clk,
    input  logic              clr_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W:0]   req_len,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_LEN = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remain_q;
    logic              ram_re_q;
    logic [ADDR_W-1:0] ram_rd_addr_q;
    logic              re_last_q;
    logic              rvalid_q;
    logic              rv_last_q;

    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic              mem_last [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW:0]       count_q;
    logic [PW:0]       count_d;
    logic              m_valid_q;
    logic [DATA_W-1:0] m_data_q;
    logic [DATA_W-1:0] m_data_d;
    logic              m_last_q;
    logic              m_last_d;

    logic [ADDR_W:0]   len_clamped;
    logic [CW-1:0]     pending;
    logic              credit_ok;
    logic              push;
    logic              pop;
    logic              drain_done;
    logic [PW-1:0]     rd_next;

    assign len_clamped = (req_len > MAX_LEN) ? MAX_LEN : req_len;
    // Reserve a slot for every read that is issued but not yet written into the FIFO.
    assign pending     = CW'(count_q) + CW'(rvalid_q) + CW'(ram_re_q);
    assign credit_ok   = pending < CW'(FIFO_DEPTH);
    assign push        = rvalid_q;
    assign pop         = m_valid_q && m_ready;
    assign count_d     = count_q + (PW+1)'(push) - (PW+1)'(pop);
    assign rd_next     = rd_ptr_q + 1'b1;
    assign drain_done  = pop && (count_q == (PW+1)'(1)) && !push && !ram_re_q;

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign ram_re      = ram_re_q;
    assign ram_rd_addr = ram_rd_addr_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_last      = m_last_q;

    always_ff @(posedge rd_clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remain_q      <= '0;
            ram_re_q      <= 1'b0;
            ram_rd_addr_q <= '0;
            re_last_q     <= 1'b0;
        end else begin
            ram_re_q  <= 1'b0;
            re_last_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The FIFO is always empty in IDLE, so the first read needs no credit check.
                    if (req_valid && (len_clamped != '0)) begin
                        ram_re_q      <= 1'b1;
                        ram_rd_addr_q <= req_addr;
                        addr_q        <= req_addr + 1'b1;
                        remain_q      <= len_clamped - 1'b1;
                        re_last_q     <= (len_clamped == ONE_LEN);
                        state_q       <= (len_clamped == ONE_LEN) ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (credit_ok) begin
                        ram_re_q      <= 1'b1;
                        ram_rd_addr_q <= addr_q;
                        addr_q        <= addr_q + 1'b1;
                        remain_q      <= remain_q - 1'b1;
                        re_last_q     <= (remain_q == ONE_LEN);
                        if (remain_q == ONE_LEN) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The head entry is mirrored into m_data_q so the stream outputs come straight from flops.
    always_comb begin
        m_data_d = m_data_q;
        m_last_d = m_last_q;
        if (pop) begin
            if (count_q > (PW+1)'(1)) begin
                m_data_d = mem_data[rd_next];
                m_last_d = mem_last[rd_next];
            end else if (push) begin
                m_data_d = ram_data;
                m_last_d = rv_last_q;
            end
        end else if ((count_q == '0) && push) begin
            m_data_d = ram_data;
            m_last_d = rv_last_q;
        end
    end

    always_ff @(posedge rd_clk or negedge clr_n) begin
        if (!clr_n) begin
            rvalid_q  <= 1'b0;
            rv_last_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            rvalid_q  <= ram_re_q;
            rv_last_q <= re_last_q;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_next;
            count_q   <= count_d;
            m_valid_q <= (count_d != '0);
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= ram_data;
            mem_last[wr_ptr_q] <= rv_last_q;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (clr_n) begin
            assert (!(push && !pop && (count_q == (PW+1)'(FIFO_DEPTH))));
        end
    end
endmodule

// File: tb/tb_ram_burst_reader.sv
// tb/tb_ram_burst_reader.sv - scoreboard bench for ram_burst_reader
module tb_ram_burst_reader;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int FIFO_DEPTH = 4;

    logic              rd_clk = 1'b0;
    logic              clr_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [ADDR_W:0]   req_len = '0;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;

    logic [DATA_W-1:0] mem [8];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [DATA_W:0]   exp_q[$];
    logic [ADDR_W-1:0] exp_rd_q[$];
    int beat_cyc_q[$];
    int rd_cyc_q[$];

    always #5 rd_clk = ~rd_clk;

    ram_burst_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .rd_clk(rd_clk), .clr_n(clr_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .ram_re(ram_re), .ram_rd_addr(ram_rd_addr),
        .ram_data(ram_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy)
    );

    initial for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);

    always @(posedge rd_clk) if (ram_re) ram_data <= mem[ram_rd_addr];

    // Scoreboard pop/compare point: sample at the falling edge, then advance past the rising edge.
    task automatic tick();
        logic [DATA_W:0] e;
        logic [ADDR_W-1:0] ea;
        @(negedge rd_clk);
        if (clr_n) begin
            if (m_valid && m_ready) begin
                vectors++;
                beat_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL beat_unexpected: got data=%h last=%b, required no beat", m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin
                        miscompares++;
                        $display("FAIL beat_data: got data=%h last=%b, required data=%h last=%b",
                                 m_data, m_last, e[DATA_W-1:0], e[DATA_W]);
                    end
                end
            end
            if (ram_re) begin
                vectors++;
                rd_cyc_q.push_back(cyc);
                if (exp_rd_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL read_unexpected: got ram_re at addr %0d, required none", ram_rd_addr);
                end else begin
                    ea = exp_rd_q.pop_front();
                    if (ram_rd_addr !== ea) begin
                        miscompares++;
                        $display("FAIL read_addr: got %0d, required %0d", ram_rd_addr, ea);
                    end
                end
            end
        end
        @(posedge rd_clk);
        cyc++;
        #1;
    endtask

    task automatic push_expect(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] l);
        int n;
        n = (l > 8) ? 8 : int'(l);
        for (int i = 0; i < n; i++) begin
            logic [ADDR_W-1:0] ra;
            ra = a + ADDR_W'(i);
            exp_rd_q.push_back(ra);
            exp_q.push_back({(i == n - 1), 16'h1000 + 16'(ra)});
        end
    endtask

    task automatic request(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] l);
        int n = 0;
        while (!req_ready && n < 200) begin tick(); n++; end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL req_ready_timeout: got req_ready=%b, required 1", req_ready);
        end
        req_valid = 1'b1; req_addr = a; req_len = l;
        push_expect(a, l);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || m_valid) && n < 300) begin tick(); n++; end
        vectors++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle: got busy=%b m_valid=%b, required 0 0", name, busy, m_valid);
        end
        vectors++;
        if (exp_q.size() != 0 || exp_rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_outstanding: got %0d beats %0d reads pending, required 0 0",
                     name, exp_q.size(), exp_rd_q.size());
        end
    endtask

    task automatic clear_logs();
        beat_cyc_q.delete();
        rd_cyc_q.delete();
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        repeat (3) @(posedge rd_clk);
        #1;
        vectors++;
        if ({ram_re, ram_rd_addr, m_valid, m_data, m_last, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got re=%b addr=%0d valid=%b data=%h last=%b busy=%b, required all 0",
                     ram_re, ram_rd_addr, m_valid, m_data, m_last, busy);
        end
        clr_n = 1'b1;
        tick();
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_req_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_basic();
        m_ready = 1'b1;
        clear_logs();
        request(3'd2, 4'd3);
        wait_idle("basic");
        vectors++;
        if (beat_cyc_q.size() != 3 || rd_cyc_q.size() != 3) begin
            miscompares++;
            $display("FAIL basic_counts: got %0d beats %0d reads, required 3 3", beat_cyc_q.size(), rd_cyc_q.size());
        end else begin
            vectors++;
            if (rd_cyc_q[2] - rd_cyc_q[0] != 2 || beat_cyc_q[2] - beat_cyc_q[0] != 2) begin
                miscompares++;
                $display("FAIL basic_spacing: got read span %0d beat span %0d, required 2 2",
                         rd_cyc_q[2] - rd_cyc_q[0], beat_cyc_q[2] - beat_cyc_q[0]);
            end
            vectors++;
            if (beat_cyc_q[0] - rd_cyc_q[0] != 2) begin
                miscompares++;
                $display("FAIL basic_latency: got %0d cycles, required 2", beat_cyc_q[0] - rd_cyc_q[0]);
            end
        end
    endtask

    task automatic test_wrap();
        m_ready = 1'b1;
        clear_logs();
        request(3'd6, 4'd4);
        wait_idle("wrap");
        vectors++;
        if (beat_cyc_q.size() != 4) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d beats, required 4", beat_cyc_q.size());
        end else if (beat_cyc_q[3] - beat_cyc_q[0] != 3) begin
            miscompares++;
            $display("FAIL wrap_bubbles: got beat span %0d, required 3", beat_cyc_q[3] - beat_cyc_q[0]);
        end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        clear_logs();
        request(3'd0, 4'd8);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_valid) begin
                vectors++;
                if (m_data !== 16'h1000 || m_last !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_frozen: got data=%h last=%b, required data=1000 last=0", m_data, m_last);
                end
            end
        end
        vectors++;
        if (rd_cyc_q.size() != FIFO_DEPTH || ram_re !== 1'b0 || m_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_credit: got %0d reads re=%b valid=%b, required %0d reads re=0 valid=1",
                     rd_cyc_q.size(), ram_re, m_valid, FIFO_DEPTH);
        end
        m_ready = 1'b1;
        wait_idle("bp_release");
        vectors++;
        if (beat_cyc_q.size() != 8) begin
            miscompares++;
            $display("FAIL bp_beats: got %0d, required 8", beat_cyc_q.size());
        end
        clear_logs();
        request(3'd0, 4'd8);
        for (int n = 0; busy && n < 200; n++) begin
            m_ready = ~m_ready;
            tick();
        end
        m_ready = 1'b1;
        wait_idle("bp_toggle");
        vectors++;
        if (beat_cyc_q.size() != 8) begin
            miscompares++;
            $display("FAIL toggle_beats: got %0d, required 8", beat_cyc_q.size());
        end
    endtask

    task automatic test_len_edges();
        m_ready = 1'b1;
        clear_logs();
        request(3'd3, 4'd0);
        vectors++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_state: got req_ready=%b busy=%b, required 1 0", req_ready, busy);
        end
        repeat (5) tick();
        vectors++;
        if (rd_cyc_q.size() != 0 || beat_cyc_q.size() != 0) begin
            miscompares++;
            $display("FAIL len0_activity: got %0d reads %0d beats, required 0 0", rd_cyc_q.size(), beat_cyc_q.size());
        end
        request(3'd5, 4'd12);
        wait_idle("len12");
        vectors++;
        if (beat_cyc_q.size() != 8) begin
            miscompares++;
            $display("FAIL len12_clamp: got %0d beats, required 8", beat_cyc_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        m_ready = 1'b1;
        clear_logs();
        request(3'd0, 4'd8);
        while (beat_cyc_q.size() < 2 && n < 50) begin tick(); n++; end
        clr_n = 1'b0;
        #2;
        vectors++;
        if ({m_valid, ram_re, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL midreset_outputs: got valid=%b re=%b busy=%b, required 0 0 0", m_valid, ram_re, busy);
        end
        exp_q.delete();
        exp_rd_q.delete();
        repeat (2) tick();
        clr_n = 1'b1;
        clear_logs();
        tick();
        request(3'd0, 4'd2);
        wait_idle("midreset_after");
        vectors++;
        if (beat_cyc_q.size() != 2) begin
            miscompares++;
            $display("FAIL midreset_beats: got %0d, required 2", beat_cyc_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        m_ready = 1'b1;
        clear_logs();
        request(3'd1, 4'd3);
        req_valid = 1'b1; req_addr = 3'd5; req_len = 4'd2;
        while (!req_ready && n < 50) begin
            if (exp_q.size() > 0) begin
                vectors++;
                if (req_ready !== 1'b0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_blocked: got req_ready=%b busy=%b, required 0 1", req_ready, busy);
                end
            end
            tick();
            n++;
        end
        vectors++;
        if (req_ready !== 1'b1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: got req_ready=%b pending=%0d, required 1 0", req_ready, exp_q.size());
        end
        push_expect(3'd5, 4'd2);
        tick();
        req_valid = 1'b0;
        wait_idle("b2b");
        vectors++;
        if (rd_cyc_q.size() != 5 || beat_cyc_q.size() != 5) begin
            miscompares++;
            $display("FAIL b2b_counts: got %0d reads %0d beats, required 5 5", rd_cyc_q.size(), beat_cyc_q.size());
        end else if (rd_cyc_q[3] - beat_cyc_q[2] != 2) begin
            miscompares++;
            $display("FAIL b2b_gap: got %0d edges, required 2", rd_cyc_q[3] - beat_cyc_q[2]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len_edges();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule
